// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for the shared memory port arbiter: the inst-side
// and data-side requester handshakes plus the single downstream memory port.
// "master" is the environment (requesters and memory slave); "slave" is the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                inst_req;
    logic                inst_wr;
    logic [1:0]          inst_size;
    logic [ADDR_W-1:0]   inst_addr;
    logic [DATA_W/8-1:0] inst_wstrb;
    logic [DATA_W-1:0]   inst_wdata;
    logic                inst_addr_ok;
    logic                inst_data_ok;
    logic [DATA_W-1:0]   inst_rdata;

    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    logic                mem_req;
    logic                mem_wr;
    logic [1:0]          mem_size;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters.
// One transaction at a time: IDLE picks a winner and latches its request,
// REQ presents it downstream until accepted, RESP waits for the response.
// Handshake acks are combinational from the downstream handshake so a
// single-cycle slave sees no added latency beyond the grant cycle.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 1    // 0: data always wins ties, 1: round-robin
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;       // 0 = inst, 1 = data
    logic                r_last_grant;  // 0 = inst, 1 = data
    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_any_req;
    logic                w_pick_data;
    logic                w_grant;
    logic                w_mem_req;
    logic                w_addr_ok;
    logic                w_data_ok;

    assign w_any_req = bus.inst_req | bus.data_req;
    assign w_grant   = (r_state == S_IDLE) && w_any_req;

    // Winner selection: a lone requester wins; ties follow ARB_MODE.
    always_comb begin
        w_pick_data = 1'b0;
        if (bus.data_req && !bus.inst_req) begin
            w_pick_data = 1'b1;
        end else if (bus.data_req && bus.inst_req) begin
            w_pick_data = (ARB_MODE == 0) ? 1'b1 : ~r_last_grant;
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winner and its request fields at grant time so the
    // downstream request stays stable even if the requester misbehaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= '0;
            r_addr       <= '0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_owner      <= w_pick_data;
            r_last_grant <= w_pick_data;
            r_wr         <= w_pick_data ? bus.data_wr    : bus.inst_wr;
            r_size       <= w_pick_data ? bus.data_size  : bus.inst_size;
            r_addr       <= w_pick_data ? bus.data_addr  : bus.inst_addr;
            r_wstrb      <= w_pick_data ? bus.data_wstrb : bus.inst_wstrb;
            r_wdata      <= w_pick_data ? bus.data_wdata : bus.inst_wdata;
        end
    end

    // Next state and downstream handshake; a zero-latency slave may accept
    // and respond in the same REQ cycle, which returns straight to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_addr_ok   = 1'b0;
        w_data_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_mem_req = 1'b1;
                if (bus.mem_addr_ok) begin
                    w_addr_ok = 1'b1;
                    if (bus.mem_data_ok) begin
                        w_data_ok   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.mem_data_ok) begin
                    w_data_ok   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_wr       = r_wr;
    assign bus.mem_size     = r_size;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wstrb    = r_wstrb;
    assign bus.mem_wdata    = r_wdata;

    assign bus.inst_addr_ok = w_addr_ok & ~r_owner;
    assign bus.data_addr_ok = w_addr_ok &  r_owner;
    assign bus.inst_data_ok = w_data_ok & ~r_owner;
    assign bus.data_data_ok = w_data_ok &  r_owner;

    // Read data is a plain pass-through, forced quiet while reset is held.
    assign bus.inst_rdata   = reset ? '0 : bus.mem_rdata;
    assign bus.data_rdata   = reset ? '0 : bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per arbitration mode, fed the same
// requester stimulus, each with its own memory slave (auto single-cycle,
// zero-latency or manual). A transaction-level model predicts every output
// on every falling edge; directed literal checks pin the model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 0, data_size = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, inst_wdata = 0, data_wdata = 0;
    logic [3:0]  inst_wstrb = 0, data_wstrb = 0;

    int          smode = 2;           // 0 auto single-cycle, 1 zero-latency, 2 manual
    logic        man_aok = 0, man_dok = 0;
    logic [31:0] man_rd = 0;
    logic        pend0 = 0, pend1 = 0;
    logic [31:0] prd0 = 0, prd1 = 0;

    int n_chk = 0, n_pass = 0;
    bit chk_rd = 0;
    int q0[$], q1[$];

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign b0.inst_req = inst_req;     assign b1.inst_req = inst_req;
    assign b0.inst_wr = inst_wr;       assign b1.inst_wr = inst_wr;
    assign b0.inst_size = inst_size;   assign b1.inst_size = inst_size;
    assign b0.inst_addr = inst_addr;   assign b1.inst_addr = inst_addr;
    assign b0.inst_wstrb = inst_wstrb; assign b1.inst_wstrb = inst_wstrb;
    assign b0.inst_wdata = inst_wdata; assign b1.inst_wdata = inst_wdata;
    assign b0.data_req = data_req;     assign b1.data_req = data_req;
    assign b0.data_wr = data_wr;       assign b1.data_wr = data_wr;
    assign b0.data_size = data_size;   assign b1.data_size = data_size;
    assign b0.data_addr = data_addr;   assign b1.data_addr = data_addr;
    assign b0.data_wstrb = data_wstrb; assign b1.data_wstrb = data_wstrb;
    assign b0.data_wdata = data_wdata; assign b1.data_wdata = data_wdata;

    // Memory slaves
    assign b0.mem_addr_ok = (smode == 2) ? man_aok : b0.mem_req;
    assign b1.mem_addr_ok = (smode == 2) ? man_aok : b1.mem_req;
    assign b0.mem_data_ok = (smode == 2) ? man_dok : (smode == 1) ? b0.mem_req : pend0;
    assign b1.mem_data_ok = (smode == 2) ? man_dok : (smode == 1) ? b1.mem_req : pend1;
    assign b0.mem_rdata = (smode == 2) ? man_rd : (smode == 1) ? rd_of(b0.mem_addr) : prd0;
    assign b1.mem_rdata = (smode == 2) ? man_rd : (smode == 1) ? rd_of(b1.mem_addr) : prd1;
    always @(posedge clk) begin
        pend0 <= (smode == 0) && b0.mem_req;
        pend1 <= (smode == 0) && b1.mem_req;
        prd0  <= rd_of(b0.mem_addr);
        prd1  <= rd_of(b1.mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: per instance, at most one transaction record.
    int          m_mode [2] = '{0, 1};
    logic        m_busy [2], m_acc [2], m_owner [2], m_last [2], m_wr [2];
    logic [1:0]  m_size [2];
    logic [31:0] m_addr [2], m_wdata [2];
    logic [3:0]  m_wstrb [2];

    task automatic model_step(input int k, input logic mreq, input logic mwr, input logic [1:0] msize,
                              input logic [31:0] maddr, input logic [3:0] mwstrb, input logic [31:0] mwdata,
                              input logic iaok, input logic idok, input logic [31:0] ird,
                              input logic daok, input logic ddok, input logic [31:0] drd,
                              input logic aok_in, input logic dok_in, input logic [31:0] rd_in);
        logic e_req, e_aok, e_dok, pick;
        string p;
        p = $sformatf("m%0d_", k);
        if (reset) begin
            chk({p, "rst_ctl"}, {mreq, mwr, msize, iaok, idok, daok, ddok}, 0);
            chk({p, "rst_addr"}, maddr, 0);
            chk({p, "rst_wstrb"}, mwstrb, 0);
            chk({p, "rst_wdata"}, mwdata, 0);
            chk({p, "rst_irdata"}, ird, 0);
            chk({p, "rst_drdata"}, drd, 0);
            m_busy[k] = 0; m_acc[k] = 0; m_owner[k] = 0; m_last[k] = 0;
            m_wr[k] = 0; m_size[k] = 0; m_addr[k] = 0; m_wstrb[k] = 0; m_wdata[k] = 0;
            return;
        end
        e_req = m_busy[k] && !m_acc[k];
        e_aok = e_req && aok_in;
        e_dok = m_busy[k] && (m_acc[k] || aok_in) && dok_in;
        chk({p, "mem_req"}, mreq, e_req);
        chk({p, "inst_addr_ok"}, iaok, e_aok && !m_owner[k]);
        chk({p, "data_addr_ok"}, daok, e_aok && m_owner[k]);
        chk({p, "inst_data_ok"}, idok, e_dok && !m_owner[k]);
        chk({p, "data_data_ok"}, ddok, e_dok && m_owner[k]);
        if (e_req) begin
            chk({p, "mem_wr"}, mwr, m_wr[k]);
            chk({p, "mem_size"}, msize, m_size[k]);
            chk({p, "mem_addr"}, maddr, m_addr[k]);
            chk({p, "mem_wstrb"}, mwstrb, m_wstrb[k]);
            chk({p, "mem_wdata"}, mwdata, m_wdata[k]);
        end
        if (e_dok && !m_owner[k]) chk({p, "inst_rdata"}, ird, rd_in);
        if (e_dok && m_owner[k])  chk({p, "data_rdata"}, drd, rd_in);
        if (m_busy[k]) begin
            if (e_dok) m_busy[k] = 0;
            else if (e_aok) m_acc[k] = 1;
        end else if (inst_req || data_req) begin
            pick = data_req && (!inst_req || m_mode[k] == 0 || !m_last[k]);
            m_busy[k] = 1; m_acc[k] = 0; m_owner[k] = pick; m_last[k] = pick;
            m_wr[k]    = pick ? data_wr    : inst_wr;
            m_size[k]  = pick ? data_size  : inst_size;
            m_addr[k]  = pick ? data_addr  : inst_addr;
            m_wstrb[k] = pick ? data_wstrb : inst_wstrb;
            m_wdata[k] = pick ? data_wdata : inst_wdata;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, b0.mem_req, b0.mem_wr, b0.mem_size, b0.mem_addr, b0.mem_wstrb, b0.mem_wdata,
                   b0.inst_addr_ok, b0.inst_data_ok, b0.inst_rdata, b0.data_addr_ok, b0.data_data_ok,
                   b0.data_rdata, b0.mem_addr_ok, b0.mem_data_ok, b0.mem_rdata);
        model_step(1, b1.mem_req, b1.mem_wr, b1.mem_size, b1.mem_addr, b1.mem_wstrb, b1.mem_wdata,
                   b1.inst_addr_ok, b1.inst_data_ok, b1.inst_rdata, b1.data_addr_ok, b1.data_data_ok,
                   b1.data_rdata, b1.mem_addr_ok, b1.mem_data_ok, b1.mem_rdata);
    end

    // Grant-order recorder and per-requester read-data check
    always @(negedge clk) begin
        if (!reset) begin
            if (b0.inst_addr_ok) q0.push_back(0);
            if (b0.data_addr_ok) q0.push_back(1);
            if (b1.inst_addr_ok) q1.push_back(0);
            if (b1.data_addr_ok) q1.push_back(1);
            if (chk_rd) begin
                if (b0.inst_data_ok) chk("rr0_inst_rdata", b0.inst_rdata, rd_of(inst_addr));
                if (b0.data_data_ok) chk("rr0_data_rdata", b0.data_rdata, rd_of(data_addr));
                if (b1.inst_data_ok) chk("rr1_inst_rdata", b1.inst_rdata, rd_of(inst_addr));
                if (b1.data_data_ok) chk("rr1_data_rdata", b1.data_rdata, rd_of(data_addr));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1);
    end

    int e0 [6] = '{1, 1, 1, 1, 0, 0};
    int e1 [6] = '{1, 0, 1, 0, 0, 0};

    initial begin
        // Reset
        @(negedge clk);
        chk("rst_mem_req", b1.mem_req, 0);
        chk("rst_inst_rdata", b1.inst_rdata, 0);
        step(); step(); reset = 0;

        // Single inst read, manual slave
        step(); inst_req = 1; inst_addr = 32'h1C00_0000;
        @(negedge clk); chk("B_c0_mem_req", b1.mem_req, 0);
        step(); man_aok = 1;
        @(negedge clk);
        chk("B_c1_inst_addr_ok", b1.inst_addr_ok, 1);
        chk("B_c1_data_addr_ok", b1.data_addr_ok, 0);
        chk("B_c1_mem_addr", b1.mem_addr, 32'h1C00_0000);
        step(); inst_req = 0; man_aok = 0; man_dok = 1; man_rd = 32'h0280_0C0C;
        @(negedge clk);
        chk("B_c2_inst_data_ok", b1.inst_data_ok, 1);
        chk("B_c2_inst_rdata", b1.inst_rdata, 32'h0280_0C0C);
        chk("B_c2_data_data_ok", b1.data_data_ok, 0);
        chk("B_c2_mem_req", b1.mem_req, 0);
        step(); man_dok = 0;

        // Tie, both requests held, auto single-cycle slave
        step(); smode = 0; q0.delete(); q1.delete(); chk_rd = 1;
        inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200;
        repeat (12) step();
        data_req = 0;
        repeat (6) step();
        inst_req = 0;
        repeat (3) step();
        chk_rd = 0;
        chk("C_q0_len", q0.size(), 6);
        chk("C_q1_len", q1.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < q0.size()) chk($sformatf("C_fixed_grant%0d", i), q0[i], e0[i]);
            if (i < q1.size()) chk($sformatf("C_rr_grant%0d", i), q1[i], e1[i]);
        end

        // Data write, manual slave with a one-cycle accept delay
        step(); smode = 2; man_aok = 0; man_dok = 0;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8; data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
        step();
        @(negedge clk);
        chk("D_mem_req", b1.mem_req, 1);
        chk("D_mem_wr", b1.mem_wr, 1);
        chk("D_mem_wstrb", b1.mem_wstrb, 4'b0011);
        chk("D_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
        chk("D_mem_addr", b1.mem_addr, 32'h8);
        chk("D_early_addr_ok", b1.data_addr_ok, 0);
        step(); man_aok = 1;
        @(negedge clk); chk("D_data_addr_ok", b1.data_addr_ok, 1);
        step(); data_req = 0; data_wr = 0; data_wstrb = 0; data_wdata = 0; man_aok = 0; man_dok = 1; man_rd = 0;
        @(negedge clk);
        chk("D_data_data_ok", b1.data_data_ok, 1);
        chk("D_inst_data_ok", b1.inst_data_ok, 0);
        step(); man_dok = 0;

        // Zero-latency slave, tie; last grant was data so round-robin picks inst
        step(); smode = 1; inst_req = 1; inst_addr = 32'h300; data_req = 1; data_addr = 32'h400;
        step();
        @(negedge clk);
        chk("E_c1_inst_addr_ok", b1.inst_addr_ok, 1);
        chk("E_c1_inst_data_ok", b1.inst_data_ok, 1);
        chk("E_c1_inst_rdata", b1.inst_rdata, rd_of(32'h300));
        chk("E_c1_fixed_data_ok", b0.data_data_ok, 1);
        step();
        @(negedge clk);
        chk("E_c2_mem_req", b1.mem_req, 0);
        step();
        @(negedge clk);
        chk("E_c3_data_addr_ok", b1.data_addr_ok, 1);
        chk("E_c3_data_data_ok", b1.data_data_ok, 1);
        chk("E_c3_data_rdata", b1.data_rdata, rd_of(32'h400));
        step(); inst_req = 0; data_req = 0;

        // Reset while in RESP
        step(); smode = 2; man_aok = 0; man_dok = 0; inst_req = 1; inst_addr = 32'h40;
        step(); man_aok = 1;
        @(negedge clk); chk("F_inst_addr_ok", b1.inst_addr_ok, 1);
        step(); man_aok = 0; inst_req = 0; reset = 1; man_dok = 1; man_rd = 32'h1234;
        @(negedge clk);
        chk("F_rst_inst_data_ok", b1.inst_data_ok, 0);
        chk("F_rst_inst_rdata", b1.inst_rdata, 0);
        chk("F_rst_mem_addr", b1.mem_addr, 0);
        step(); reset = 0;
        @(negedge clk);
        chk("F_idle_inst_data_ok1", b1.inst_data_ok, 0);
        chk("F_idle_inst_data_ok0", b0.inst_data_ok, 0);
        step(); man_dok = 0; data_req = 1; data_addr = 32'h80;
        step(); man_aok = 1;
        @(negedge clk); chk("F_data_addr_ok", b1.data_addr_ok, 1);
        step(); data_req = 0; man_aok = 0; man_dok = 1; man_rd = 32'hCAFE_F00D;
        @(negedge clk);
        chk("F_data_data_ok", b1.data_data_ok, 1);
        chk("F_data_rdata", b1.data_rdata, 32'hCAFE_F00D);
        step(); man_dok = 0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
